// File: rtl/axil_apb_pkg.sv
// -----------------------------------------------------------------------------
// axil_apb_pkg
// Shared types and constants for the AXI4-Lite to APB4 bridge.
//   state_t        : bridge FSM states
//   RESP_OKAY      : AXI/APB OKAY response code
//   RESP_SLVERR    : AXI SLVERR response code
//   tmo_cnt_width  : width of the ACCESS timeout counter (APB_TIMEOUT_EN builds)
// -----------------------------------------------------------------------------
package axil_apb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        WRESP  = 3'd3,
        RRESP  = 3'd4
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Counter must hold values 0 .. cycles-1; never narrower than one bit.
    function automatic int tmo_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/axil_apb_bridge.sv
// -----------------------------------------------------------------------------
// axil_apb_bridge
// AXI4-Lite slave to APB4 master bridge. One APB transfer at a time; AW, W and
// AR each have a one-entry holding register so the next request is captured
// while an access is in flight. Reads and writes that are pending together
// are served alternately.
//
// Build option: define APB_TIMEOUT_EN to end an ACCESS phase that has waited
// TIMEOUT_CYCLES cycles for pready with SLVERR (read data returned as 0).
//
// Ports:
//   axilite_clk, axilite_rst     clock, synchronous active-high reset
//   s_axil_aw* / w* / b*         AXI4-Lite write address, data, response
//   s_axil_ar* / r*              AXI4-Lite read address, data/response
//   m_apb_paddr .. m_apb_pprot   APB4 request outputs
//   m_apb_pready/prdata/pslverr  APB4 completer inputs
// -----------------------------------------------------------------------------
module axil_apb_bridge
    import axil_apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    axilite_clk,
    input  logic                    axilite_rst,
    // AXI4-Lite slave
    input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic [2:0]              s_axil_awprot,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    output logic [1:0]              s_axil_bresp,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic [2:0]              s_axil_arprot,
    input  logic                    s_axil_arvalid,
    output logic                    s_axil_arready,
    output logic [DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]              s_axil_rresp,
    output logic                    s_axil_rvalid,
    input  logic                    s_axil_rready,
    // APB4 master
    output logic [ADDR_WIDTH-1:0]   m_apb_paddr,
    output logic                    m_apb_psel,
    output logic                    m_apb_penable,
    output logic                    m_apb_pwrite,
    output logic [DATA_WIDTH-1:0]   m_apb_pwdata,
    output logic [DATA_WIDTH/8-1:0] m_apb_pstrb,
    output logic [2:0]              m_apb_pprot,
    input  logic                    m_apb_pready,
    input  logic [DATA_WIDTH-1:0]   m_apb_prdata,
    input  logic                    m_apb_pslverr
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    if (TIMEOUT_CYCLES < 1 || (DATA_WIDTH % 8) != 0) begin : g_param_check
        $error("axil_apb_bridge: TIMEOUT_CYCLES must be >= 1 and DATA_WIDTH a multiple of 8");
    end

    state_t state, state_nxt;

    logic                  rdy_en;        // holds all readies low in the cycle after reset
    logic                  prio_write;    // contention winner: 1 = write, 0 = read
    logic                  aw_full, w_full, ar_full;
    logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
    logic [2:0]            aw_prot, ar_prot;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;

    logic                  wr_pend, rd_pend, issue_wr, issue_rd;
    logic                  access_done, access_err;
    logic [DATA_WIDTH-1:0] rd_data_in;

    assign wr_pend  = aw_full && w_full;
    assign rd_pend  = ar_full;
    assign issue_wr = (state == IDLE) && wr_pend && (!rd_pend || prio_write);
    assign issue_rd = (state == IDLE) && rd_pend && (!wr_pend || !prio_write);

    assign s_axil_awready = rdy_en && !aw_full;
    assign s_axil_wready  = rdy_en && !w_full;
    assign s_axil_arready = rdy_en && !ar_full;

`ifdef APB_TIMEOUT_EN
    localparam int                TMO_W    = tmo_cnt_width(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;

    assign tmo_hit = !m_apb_pready && (tmo_cnt == TMO_LAST);

    always_ff @(posedge axilite_clk) begin
        if (axilite_rst) begin
            tmo_cnt <= '0;
        end else if (state == SETUP) begin
            tmo_cnt <= '0;
        end else if (state == ACCESS && !m_apb_pready && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // A timed-out access behaves as pready with pslverr and zero read data.
    assign access_done = (state == ACCESS) && (m_apb_pready || tmo_hit);
    assign access_err  = !m_apb_pready || m_apb_pslverr;
    assign rd_data_in  = m_apb_pready ? m_apb_prdata : '0;
`else
    assign access_done = (state == ACCESS) && m_apb_pready;
    assign access_err  = m_apb_pslverr;
    assign rd_data_in  = m_apb_prdata;
`endif

    // ---------------- FSM: state register ----------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge axilite_clk) begin
        if (axilite_rst) state <= IDLE;
        else             state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: the default assignment first keeps this purely combinational;
    // a path that left state_nxt unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (issue_wr || issue_rd) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (access_done) state_nxt = m_apb_pwrite ? WRESP : RRESP;
            WRESP:   if (s_axil_bready) state_nxt = IDLE;
            RRESP:   if (s_axil_rready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        m_apb_psel    = 1'b0;
        m_apb_penable = 1'b0;
        s_axil_bvalid = 1'b0;
        s_axil_rvalid = 1'b0;
        unique case (state)
            SETUP:   m_apb_psel = 1'b1;
            ACCESS:  begin
                m_apb_psel    = 1'b1;
                m_apb_penable = 1'b1;
            end
            WRESP:   s_axil_bvalid = 1'b1;
            RRESP:   s_axil_rvalid = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Holding register occupancy ----------------
    always_ff @(posedge axilite_clk) begin
        if (axilite_rst) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            ar_full <= 1'b0;
        end else begin
            if (s_axil_awvalid && s_axil_awready) aw_full <= 1'b1;
            else if (issue_wr)                    aw_full <= 1'b0;
            if (s_axil_wvalid && s_axil_wready)   w_full  <= 1'b1;
            else if (issue_wr)                    w_full  <= 1'b0;
            if (s_axil_arvalid && s_axil_arready) ar_full <= 1'b1;
            else if (issue_rd)                    ar_full <= 1'b0;
        end
    end

    // NOTE: payload registers carry no reset; they are only read while the
    // matching *_full flag is set, and that flag is reset.
    always_ff @(posedge axilite_clk) begin
        if (s_axil_awvalid && s_axil_awready) begin
            aw_addr <= s_axil_awaddr;
            aw_prot <= s_axil_awprot;
        end
        if (s_axil_wvalid && s_axil_wready) begin
            w_data <= s_axil_wdata;
            w_strb <= s_axil_wstrb;
        end
        if (s_axil_arvalid && s_axil_arready) begin
            ar_addr <= s_axil_araddr;
            ar_prot <= s_axil_arprot;
        end
    end

    // ---------------- APB request and AXI response registers ----------------
    always_ff @(posedge axilite_clk) begin
        if (axilite_rst) begin
            rdy_en       <= 1'b0;
            prio_write   <= 1'b1;
            m_apb_paddr  <= '0;
            m_apb_pwrite <= 1'b0;
            m_apb_pwdata <= '0;
            m_apb_pstrb  <= '0;
            m_apb_pprot  <= '0;
            s_axil_bresp <= RESP_OKAY;
            s_axil_rresp <= RESP_OKAY;
            s_axil_rdata <= '0;
        end else begin
            rdy_en <= 1'b1;
            // The priority flag only moves when both types were competing.
            if (issue_wr) begin
                m_apb_paddr  <= aw_addr;
                m_apb_pprot  <= aw_prot;
                m_apb_pwrite <= 1'b1;
                m_apb_pwdata <= w_data;
                m_apb_pstrb  <= w_strb;
                if (rd_pend) prio_write <= 1'b0;
            end else if (issue_rd) begin
                m_apb_paddr  <= ar_addr;
                m_apb_pprot  <= ar_prot;
                m_apb_pwrite <= 1'b0;
                m_apb_pwdata <= '0;
                m_apb_pstrb  <= '0;
                if (wr_pend) prio_write <= 1'b1;
            end
            if (access_done) begin
                if (m_apb_pwrite) begin
                    s_axil_bresp <= access_err ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    s_axil_rdata <= rd_data_in;
                    s_axil_rresp <= access_err ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

endmodule

// File: tb/tb_axil_apb_bridge.sv
// -----------------------------------------------------------------------------
// tb_axil_apb_bridge
// Self-checking bench for axil_apb_bridge. Expected APB transfers and AXI
// responses are queued when stimulus is driven and compared when the bridge
// produces them. Define APB_TIMEOUT_EN to exercise the timeout build.
// -----------------------------------------------------------------------------
module tb_axil_apb_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic [2:0]    awprot = '0, arprot = '0;
    logic          awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic          awready, wready, arready;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;
    logic [1:0]    bresp, rresp;
    logic          bvalid, rvalid;
    logic          bready = 1'b1, rready = 1'b1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] paddr;
    logic          psel, penable, pwrite;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [2:0]    pprot;
    logic          pready = 1'b0;
    logic [DW-1:0] prdata = '0;
    logic          pslverr = 1'b0;

    axil_apb_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
    ) dut (
        .axilite_clk(clk),          .axilite_rst(rst),
        .s_axil_awaddr(awaddr),     .s_axil_awprot(awprot),
        .s_axil_awvalid(awvalid),   .s_axil_awready(awready),
        .s_axil_wdata(wdata),       .s_axil_wstrb(wstrb),
        .s_axil_wvalid(wvalid),     .s_axil_wready(wready),
        .s_axil_bresp(bresp),       .s_axil_bvalid(bvalid),
        .s_axil_bready(bready),
        .s_axil_araddr(araddr),     .s_axil_arprot(arprot),
        .s_axil_arvalid(arvalid),   .s_axil_arready(arready),
        .s_axil_rdata(rdata),       .s_axil_rresp(rresp),
        .s_axil_rvalid(rvalid),     .s_axil_rready(rready),
        .m_apb_paddr(paddr),        .m_apb_psel(psel),
        .m_apb_penable(penable),    .m_apb_pwrite(pwrite),
        .m_apb_pwdata(pwdata),      .m_apb_pstrb(pstrb),
        .m_apb_pprot(pprot),        .m_apb_pready(pready),
        .m_apb_prdata(prdata),      .m_apb_pslverr(pslverr)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [2:0]    prot;
    } apb_exp_t;

    typedef struct packed {
        logic          wr;
        logic [1:0]    resp;
        logic [DW-1:0] rdata;
    } rsp_exp_t;

    apb_exp_t exp_apb[$];
    rsp_exp_t exp_rsp[$];
    int       setup_hist[$];
    int       cyc = 0;
    int       acc_cnt = 0;
    apb_exp_t mon_a;
    rsp_exp_t mon_r;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (psel && !penable) begin
                setup_hist.push_back(cyc);
                if (exp_apb.size() == 0) begin
                    check("apb_unexpected_setup", 1, 0);
                end else begin
                    mon_a = exp_apb.pop_front();
                    check("apb_pwrite", pwrite, mon_a.wr);
                    check("apb_paddr",  paddr,  mon_a.addr);
                    check("apb_pwdata", pwdata, mon_a.data);
                    check("apb_pstrb",  pstrb,  mon_a.strb);
                    check("apb_pprot",  pprot,  mon_a.prot);
                end
            end
            if (psel && penable) acc_cnt++;
            if (bvalid && bready) begin
                if (exp_rsp.size() == 0) begin
                    check("b_unexpected", 1, 0);
                end else begin
                    mon_r = exp_rsp.pop_front();
                    check("b_kind_resp", {1'b1, bresp}, {mon_r.wr, mon_r.resp});
                end
            end
            if (rvalid && rready) begin
                if (exp_rsp.size() == 0) begin
                    check("r_unexpected", 1, 0);
                end else begin
                    mon_r = exp_rsp.pop_front();
                    check("r_kind_resp", {1'b0, rresp}, {mon_r.wr, mon_r.resp});
                    check("r_data", rdata, mon_r.rdata);
                end
            end
        end
    end

    // ---------------- APB completer model ----------------
    int rsp_wait   = 0;
    int acc_seen   = 0;
    int pready_cyc = -1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (psel && penable) begin
                if (acc_seen >= rsp_wait && !pready) pready_cyc = cyc;
                pready = (acc_seen >= rsp_wait);
                acc_seen++;
            end else begin
                acc_seen = 0;
                pready   = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [SW-1:0] s, input logic [2:0] p, input logic [1:0] r);
        exp_apb.push_back('{wr: 1'b1, addr: a, data: d, strb: s, prot: p});
        exp_rsp.push_back('{wr: 1'b1, resp: r, rdata: '0});
    endtask

    task automatic exp_read(input logic [AW-1:0] a, input logic [2:0] p,
                            input logic [DW-1:0] d, input logic [1:0] r);
        exp_apb.push_back('{wr: 1'b0, addr: a, data: '0, strb: '0, prot: p});
        exp_rsp.push_back('{wr: 1'b0, resp: r, rdata: d});
    endtask

    // Drive the selected channels together; each valid drops once accepted.
    task automatic axi_push(input logic do_aw, input logic do_w, input logic do_ar,
                            input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                            input logic [SW-1:0] ws, input logic [2:0] wp,
                            input logic [AW-1:0] ra, input logic [2:0] rp);
        logic aw_p, w_p, ar_p, acc_aw, acc_w, acc_ar;
        aw_p = do_aw; w_p = do_w; ar_p = do_ar;
        awaddr = wa; awprot = wp; wdata = wd; wstrb = ws;
        araddr = ra; arprot = rp;
        awvalid = aw_p; wvalid = w_p; arvalid = ar_p;
        for (int i = 0; i < 50 && (aw_p || w_p || ar_p); i++) begin
            acc_aw = aw_p && awready;
            acc_w  = w_p && wready;
            acc_ar = ar_p && arready;
            tick();
            if (acc_aw) begin aw_p = 1'b0; awvalid = 1'b0; end
            if (acc_w)  begin w_p  = 1'b0; wvalid  = 1'b0; end
            if (acc_ar) begin ar_p = 1'b0; arvalid = 1'b0; end
        end
        check("push_accepted", {aw_p, w_p, ar_p}, 3'b000);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bvalid;
            1:       return rvalid;
            default: return penable;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int budget, input string tag);
        int n;
        n = 0;
        while (!sig(sel) && n < budget) begin
            tick();
            n++;
        end
        check(tag, sig(sel), 1);
    endtask

    task automatic drain(input int budget, input string tag);
        int n;
        n = 0;
        while ((exp_apb.size() != 0 || exp_rsp.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check(tag, exp_apb.size() + exp_rsp.size(), 0);
        tick();
    endtask

    task automatic do_reset();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        check("rst_psel_pen", {psel, penable}, 2'b00);
        check("rst_valids",   {bvalid, rvalid}, 2'b00);
        check("rst_readies",  {awready, wready, arready}, 3'b000);
        check("rst_apb_regs", {paddr, pwrite, pwdata, pstrb, pprot}, '0);
        check("rst_axi_regs", {rdata, bresp, rresp}, '0);
        exp_apb.delete();
        exp_rsp.delete();
        rst = 1'b0;
        tick();
        check("post_rst_readies", {awready, wready, arready}, 3'b111);
    endtask

    // ---------------- test sequence ----------------
    int bv_cnt;
    int psel_cnt;

    initial begin
        do_reset();

        // 1: single write, zero-wait APB, exact phase timing
        rsp_wait = 0;
        exp_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000, 2'b00);
        axi_push(1, 1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000, '0, '0);
        check("t1_c0_psel", psel, 1'b0);
        tick();
        check("t1_c1_psel_pen", {psel, penable}, 2'b10);
        tick();
        check("t1_c2_psel_pen", {psel, penable}, 2'b11);
        tick();
        check("t1_c3_bvalid", bvalid, 1'b1);
        drain(20, "t1_drain");

        // 2: W three cycles before AW, five wait states
        rsp_wait = 5;
        prdata   = 32'hBAD0_BAD0;
        acc_cnt  = 0;
        exp_write(32'h0000_0100, 32'hCAFE_F00D, 4'h3, 3'b001, 2'b00);
        axi_push(0, 1, 0, '0, 32'hCAFE_F00D, 4'h3, 3'b001, '0, '0);
        tick();
        tick();
        check("t2_w_only_no_psel", psel, 1'b0);
        check("t2_w_held", wready, 1'b0);
        axi_push(1, 0, 0, 32'h0000_0100, 32'hCAFE_F00D, 4'h3, 3'b001, '0, '0);
        wait_for(0, 40, "t2_bvalid");
        check("t2_bvalid_after_pready", cyc - pready_cyc, 1);
        check("t2_access_cycles", acc_cnt, 6);
        drain(20, "t2_drain");

        // 3: simultaneous read and write, alternating priority
        do_reset();
        rsp_wait = 0;
        prdata   = 32'hA5A5_0001;
        setup_hist.delete();
        exp_write(32'h0000_0040, 32'h1111_2222, 4'hC, 3'b010, 2'b00);
        exp_read (32'h0000_0044, 3'b011, 32'hA5A5_0001, 2'b00);
        axi_push(1, 1, 1, 32'h0000_0040, 32'h1111_2222, 4'hC, 3'b010, 32'h0000_0044, 3'b011);
        drain(40, "t3a_drain");
        check("t3a_two_setups", setup_hist.size(), 2);
        if (setup_hist.size() == 2) check("t3a_back_to_back", setup_hist[1] - setup_hist[0], 4);
        prdata = 32'hA5A5_0002;
        exp_read (32'h0000_0048, 3'b000, 32'hA5A5_0002, 2'b00);
        exp_write(32'h0000_004C, 32'h3333_4444, 4'h1, 3'b100, 2'b00);
        axi_push(1, 1, 1, 32'h0000_004C, 32'h3333_4444, 4'h1, 3'b100, 32'h0000_0048, 3'b000);
        drain(40, "t3b_drain");

        // 4: read with SLVERR, response held while rready is low
        rsp_wait = 0;
        prdata   = 32'h1234_5678;
        pslverr  = 1'b1;
        rready   = 1'b0;
        exp_read(32'h0000_0024, 3'b000, 32'h1234_5678, 2'b10);
        axi_push(0, 0, 1, '0, '0, '0, '0, 32'h0000_0024, 3'b000);
        wait_for(1, 20, "t4_rvalid");
        pslverr = 1'b0;
        prdata  = 32'h0;
        for (int i = 0; i < 4; i++) begin
            check("t4_rvalid_hold", rvalid, 1'b1);
            check("t4_rdata_hold", rdata, 32'h1234_5678);
            check("t4_rresp_hold", rresp, 2'b10);
            tick();
        end
        rready = 1'b1;
        drain(20, "t4_drain");

        // 5: reset while in ACCESS abandons the transfer
        rsp_wait = 100000;
        exp_write(32'h0000_0200, 32'h5555_AAAA, 4'hF, 3'b000, 2'b00);
        axi_push(1, 1, 0, 32'h0000_0200, 32'h5555_AAAA, 4'hF, 3'b000, '0, '0);
        wait_for(2, 10, "t5_in_access");
        rst = 1'b1;
        tick();
        check("t5_rst_outputs", {psel, penable, bvalid, rvalid}, 4'b0000);
        check("t5_rst_readies", {awready, wready, arready}, 3'b000);
        rst = 1'b0;
        exp_rsp.delete();
        rsp_wait = 0;
        bv_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bvalid || rvalid) bv_cnt++;
        end
        check("t5_no_response", bv_cnt, 0);
        exp_write(32'h0000_0204, 32'h0F0F_0F0F, 4'h5, 3'b000, 2'b00);
        axi_push(1, 1, 0, 32'h0000_0204, 32'h0F0F_0F0F, 4'h5, 3'b000, '0, '0);
        drain(20, "t5_fresh_write");

        // 6: completer never ready
        rsp_wait = 100000;
        prdata   = 32'hFFFF_0000;
`ifdef APB_TIMEOUT_EN
        acc_cnt = 0;
        exp_read(32'h0000_0080, 3'b000, 32'h0, 2'b10);
        axi_push(0, 0, 1, '0, '0, '0, '0, 32'h0000_0080, 3'b000);
        drain(40, "t6_timeout_drain");
        check("t6_timeout_access_cycles", acc_cnt, 8);
`else
        exp_read(32'h0000_0080, 3'b000, 32'hFFFF_0000, 2'b00);
        axi_push(0, 0, 1, '0, '0, '0, '0, 32'h0000_0080, 3'b000);
        wait_for(2, 10, "t6_in_access");
        psel_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            if (psel && penable) psel_cnt++;
            tick();
        end
        check("t6_psel_held_1000", psel_cnt, 1000);
        rsp_wait = 0;
        drain(20, "t6_release_drain");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
